// File: rtl/gshare_predictor_if.sv
// Fetch-side prediction and EX-side resolution signals of the gshare predictor.
// The pipeline acts as master; the predictor is the slave.
interface gshare_predictor_if #(
  parameter int PC_WIDTH = 32,
  parameter int PHT_BITS = 8,
  parameter int GHR_BITS = 8
);
  logic                pc_valid_unused_placeholder_n;
  logic [PC_WIDTH-1:0] pc;
  logic                fetch_valid;
  logic                pred_taken;
  logic [PC_WIDTH-1:0] pred_pc;
  logic [PHT_BITS-1:0] pred_idx;
  logic [GHR_BITS-1:0] pred_ghr;
  logic                ready;
  logic                upd_valid;
  logic [PC_WIDTH-1:0] upd_pc;
  logic                upd_is_branch;
  logic                upd_taken;
  logic [PC_WIDTH-1:0] upd_target;
  logic [PHT_BITS-1:0] upd_idx;
  logic [GHR_BITS-1:0] upd_ghr;
  logic                upd_mispredict;

  modport master (
    output pc, fetch_valid,
    output upd_valid, upd_pc, upd_is_branch, upd_taken, upd_target,
    output upd_idx, upd_ghr, upd_mispredict,
    input  pred_taken, pred_pc, pred_idx, pred_ghr, ready
  );

  modport slave (
    input  pc, fetch_valid,
    input  upd_valid, upd_pc, upd_is_branch, upd_taken, upd_target,
    input  upd_idx, upd_ghr, upd_mispredict,
    output pred_taken, pred_pc, pred_idx, pred_ghr, ready
  );
endinterface

// File: rtl/gshare_predictor.sv
// gshare branch predictor: PHT indexed by PC XOR speculative GHR plus a tagged
// direct-mapped BTB, with an init sweep after every reset.
module gshare_predictor #(
  parameter int PC_WIDTH = 32,
  parameter int PHT_BITS = 8,
  parameter int GHR_BITS = 8,
  parameter int BTB_BITS = 5,
  parameter int CTR_BITS = 2
) (
  input logic clk,
  input logic reset,
  gshare_predictor_if.slave bus
);

  localparam int PHT_ENTRIES = 1 << PHT_BITS;
  localparam int BTB_ENTRIES = 1 << BTB_BITS;
  localparam int INIT_BITS   = (PHT_BITS > BTB_BITS) ? PHT_BITS : BTB_BITS;
  localparam int TAG_BITS    = PC_WIDTH - BTB_BITS - 2;
  localparam logic [INIT_BITS-1:0] INIT_LAST   = '1;
  localparam logic [CTR_BITS-1:0]  CTR_WEAK_NT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  typedef enum logic {INIT, READY} state_t;

  state_t                r_state;
  logic [INIT_BITS-1:0]  r_initIdx;
  logic                  r_ready;
  logic [GHR_BITS-1:0]   r_specGhr;

  logic [CTR_BITS-1:0]   r_pht       [PHT_ENTRIES];
  logic                  r_btbValid  [BTB_ENTRIES];
  logic                  r_btbCond   [BTB_ENTRIES];
  logic [TAG_BITS-1:0]   r_btbTag    [BTB_ENTRIES];
  logic [PC_WIDTH-1:0]   r_btbTarget [BTB_ENTRIES];

  logic [PHT_BITS-1:0]   w_ghrExt;
  logic [PHT_BITS-1:0]   w_phtIdx;
  logic [BTB_BITS-1:0]   w_btbIdx;
  logic [TAG_BITS-1:0]   w_tag;
  logic [CTR_BITS-1:0]   w_ctr;
  logic                  w_hit;
  logic                  w_predTaken;
  logic                  w_updEn;
  logic [BTB_BITS-1:0]   w_updBtbIdx;
  logic [TAG_BITS-1:0]   w_updTag;
  logic [CTR_BITS-1:0]   w_updCtr;
  logic                  w_initPhtOk;
  logic                  w_initBtbOk;
  logic                  w_unusedBits;

  assign w_ghrExt    = PHT_BITS'(r_specGhr);
  assign w_phtIdx    = bus.pc[PHT_BITS+1:2] ^ w_ghrExt;
  assign w_btbIdx    = bus.pc[BTB_BITS+1:2];
  assign w_tag       = bus.pc[PC_WIDTH-1:BTB_BITS+2];
  assign w_ctr       = r_pht[w_phtIdx];
  // r_ready gates the hit so predictions drop the instant reset is asserted
  assign w_hit       = r_ready & r_btbValid[w_btbIdx] & (r_btbTag[w_btbIdx] == w_tag);
  assign w_predTaken = w_hit & (~r_btbCond[w_btbIdx] | w_ctr[CTR_BITS-1]);

  assign w_updEn     = bus.upd_valid & r_ready;
  assign w_updBtbIdx = bus.upd_pc[BTB_BITS+1:2];
  assign w_updTag    = bus.upd_pc[PC_WIDTH-1:BTB_BITS+2];
  assign w_updCtr    = r_pht[bus.upd_idx];

  assign w_initPhtOk = (r_initIdx >> PHT_BITS) == '0;
  assign w_initBtbOk = (r_initIdx >> BTB_BITS) == '0;
  assign w_unusedBits = ^{bus.pc[1:0], bus.upd_pc[1:0]};

  assign bus.pred_taken = w_predTaken;
  assign bus.pred_pc    = w_predTaken ? r_btbTarget[w_btbIdx] : bus.pc + PC_WIDTH'(4);
  assign bus.pred_idx   = w_phtIdx;
  assign bus.pred_ghr   = r_specGhr;
  assign bus.ready      = r_ready;

  // Table storage: swept during INIT, trained by EX resolutions afterwards
  always_ff @(posedge clk) begin
    if (!r_ready) begin
      if (w_initPhtOk) r_pht[r_initIdx[PHT_BITS-1:0]] <= CTR_WEAK_NT;
      if (w_initBtbOk) r_btbValid[r_initIdx[BTB_BITS-1:0]] <= 1'b0;
    end else if (w_updEn) begin
      if (bus.upd_is_branch) begin
        if (bus.upd_taken && (w_updCtr != '1))
          r_pht[bus.upd_idx] <= w_updCtr + CTR_BITS'(1);
        else if (!bus.upd_taken && (w_updCtr != '0))
          r_pht[bus.upd_idx] <= w_updCtr - CTR_BITS'(1);
      end
      if (bus.upd_taken) begin
        r_btbValid[w_updBtbIdx]  <= 1'b1;
        r_btbCond[w_updBtbIdx]   <= bus.upd_is_branch;
        r_btbTag[w_updBtbIdx]    <= w_updTag;
        r_btbTarget[w_updBtbIdx] <= bus.upd_target;
      end
    end
  end

  // Init sequencer and speculative history; mispredict recovery beats fetch shift
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= INIT;
      r_initIdx <= '0;
      r_ready   <= 1'b0;
      r_specGhr <= '0;
    end else begin
      case (r_state)
        INIT: begin
          r_specGhr <= '0;
          if (r_initIdx == INIT_LAST) begin
            r_state   <= READY;
            r_ready   <= 1'b1;
            r_initIdx <= '0;
          end else begin
            r_initIdx <= r_initIdx + INIT_BITS'(1);
          end
        end
        READY: begin
          if (w_updEn && bus.upd_mispredict)
            r_specGhr <= bus.upd_is_branch ? GHR_BITS'({bus.upd_ghr, bus.upd_taken})
                                           : bus.upd_ghr;
          else if (bus.fetch_valid && w_hit && r_btbCond[w_btbIdx])
            r_specGhr <= GHR_BITS'({r_specGhr, w_predTaken});
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed scoreboard bench for gshare_predictor: init length, jump capture,
// counter saturation, GHR speculation/recovery, tag aliasing and mid-run reset.
module tb_gshare_predictor;

  localparam int PC_WIDTH = 32;
  localparam int PHT_BITS = 8;
  localparam int GHR_BITS = 8;
  localparam int BTB_BITS = 5;
  localparam int CTR_BITS = 2;

  localparam int SEL_TAKEN = 0;
  localparam int SEL_PC    = 1;
  localparam int SEL_GHR   = 2;
  localparam int SEL_IDX   = 3;
  localparam int SEL_READY = 4;
  localparam int SEL_EDGES = 5;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  int   initEdges = 0;
  int   ctr5 = 1;
  exp_t sb[$];

  always #5 clk = ~clk;

  gshare_predictor_if #(.PC_WIDTH(PC_WIDTH), .PHT_BITS(PHT_BITS), .GHR_BITS(GHR_BITS)) bus ();

  gshare_predictor #(
    .PC_WIDTH(PC_WIDTH), .PHT_BITS(PHT_BITS), .GHR_BITS(GHR_BITS),
    .BTB_BITS(BTB_BITS), .CTR_BITS(CTR_BITS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  task automatic pushExp(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = val;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SEL_TAKEN: return {31'd0, bus.pred_taken};
      SEL_PC:    return bus.pred_pc;
      SEL_GHR:   return 32'(bus.pred_ghr);
      SEL_IDX:   return 32'(bus.pred_idx);
      SEL_READY: return {31'd0, bus.ready};
      default:   return 32'(initEdges);
    endcase
  endfunction

  task automatic checkOutput();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      obs = observe(e.sel);
      total++;
      assert (obs === e.exp) else begin
        bad++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input logic fv, input logic uv,
                               input logic [31:0] upc, input logic ub, input logic ut,
                               input logic [31:0] utgt, input logic [7:0] uidx,
                               input logic [7:0] ughr, input logic um);
    bus.pc             = pc;
    bus.fetch_valid    = fv;
    bus.upd_valid      = uv;
    bus.upd_pc         = upc;
    bus.upd_is_branch  = ub;
    bus.upd_taken      = ut;
    bus.upd_target     = utgt;
    bus.upd_idx        = uidx;
    bus.upd_ghr        = ughr;
    bus.upd_mispredict = um;
    #1;
  endtask

  task automatic setFetch(input logic [31:0] pc, input logic fv);
    applyStimulus(pc, fv, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 8'h0, 8'h0, 1'b0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Counts edges from reset release until ready; optionally fires updates that must be ignored
  task automatic waitReady(input logic withUpd);
    bit done;
    done = 1'b0;
    initEdges = 0;
    for (int n = 1; n <= 400 && !done; n++) begin
      @(posedge clk);
      #1;
      if (bus.ready) begin
        initEdges = n;
        done = 1'b1;
      end else if (withUpd && (n == 9 || n == 255)) begin
        applyStimulus(32'h100, 1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 32'h40, 8'h0, 8'h5A, 1'b1);
      end else if (withUpd && n == 100) begin
        setFetch(32'h100, 1'b0);
        pushExp("init_taken", SEL_TAKEN, 32'd0);
        pushExp("init_pc", SEL_PC, 32'h104);
        checkOutput();
      end else begin
        setFetch(32'h100, 1'b0);
      end
    end
  endtask

  initial begin
    logic seq [6];
    logic t;
    seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    reset = 1'b0;
    setFetch(32'h100, 1'b0);
    #1;
    pushExp("rst_taken", SEL_TAKEN, 32'd0);
    pushExp("rst_pc", SEL_PC, 32'h104);
    pushExp("rst_ghr", SEL_GHR, 32'h0);
    pushExp("rst_idx", SEL_IDX, 32'h40);
    pushExp("rst_ready", SEL_READY, 32'd0);
    checkOutput();
    cyc();
    cyc();
    reset = 1'b1;

    waitReady(1'b1);
    setFetch(32'h100, 1'b0);
    pushExp("init_edges", SEL_EDGES, 32'd256);
    pushExp("init_ready", SEL_READY, 32'd1);
    pushExp("init_ign_taken", SEL_TAKEN, 32'd0);
    pushExp("init_ign_pc", SEL_PC, 32'h104);
    pushExp("init_ign_ghr", SEL_GHR, 32'h0);
    checkOutput();

    // Jump capture: same-cycle lookup sees the old entry
    applyStimulus(32'h100, 1'b1, 1'b1, 32'h100, 1'b0, 1'b1, 32'h40, 8'h0, 8'h0, 1'b1);
    pushExp("jmp_cold_taken", SEL_TAKEN, 32'd0);
    pushExp("jmp_cold_pc", SEL_PC, 32'h104);
    checkOutput();
    cyc();
    setFetch(32'h100, 1'b1);
    pushExp("jmp_taken", SEL_TAKEN, 32'd1);
    pushExp("jmp_pc", SEL_PC, 32'h40);
    pushExp("jmp_ghr0", SEL_GHR, 32'h0);
    checkOutput();
    cyc();
    setFetch(32'h100, 1'b0);
    pushExp("jmp_noshift", SEL_GHR, 32'h0);
    checkOutput();

    // Counter saturation on pht[5]
    for (int k = 0; k < 6; k++) begin
      t = seq[k];
      applyStimulus(32'h14, 1'b0, 1'b1, 32'h14, 1'b1, t, 32'h200, 8'd5, 8'h0, 1'b0);
      cyc();
      if (t && ctr5 < 3) ctr5++;
      else if (!t && ctr5 > 0) ctr5--;
      setFetch(32'h14, 1'b0);
      pushExp($sformatf("sat_taken_%0d", k), SEL_TAKEN, (ctr5 >= 2) ? 32'd1 : 32'd0);
      pushExp($sformatf("sat_pc_%0d", k), SEL_PC, (ctr5 >= 2) ? 32'h200 : 32'h18);
      checkOutput();
    end

    // Train pht[5] and pht[4] strongly taken for the history walk
    for (int k = 0; k < 4; k++) begin
      applyStimulus(32'h14, 1'b0, 1'b1, 32'h14, 1'b1, 1'b1, 32'h200,
                    (k < 2) ? 8'd5 : 8'd4, 8'h0, 1'b0);
      cyc();
    end
    ctr5 = 3;

    setFetch(32'h14, 1'b1);
    pushExp("ghr_step0", SEL_GHR, 32'h00);
    pushExp("ghr_idx0", SEL_IDX, 32'h05);
    pushExp("ghr_taken0", SEL_TAKEN, 32'd1);
    checkOutput();
    cyc();
    pushExp("ghr_step1", SEL_GHR, 32'h01);
    pushExp("ghr_idx1", SEL_IDX, 32'h04);
    pushExp("ghr_taken1", SEL_TAKEN, 32'd1);
    pushExp("ghr_pc1", SEL_PC, 32'h200);
    checkOutput();
    cyc();
    applyStimulus(32'h14, 1'b1, 1'b1, 32'h14, 1'b1, 1'b0, 32'h0, 8'd5, 8'h01, 1'b1);
    pushExp("ghr_spec", SEL_GHR, 32'h03);
    pushExp("ghr_idx2", SEL_IDX, 32'h06);
    checkOutput();
    cyc();
    ctr5 = 2;
    setFetch(32'h14, 1'b0);
    pushExp("ghr_recover", SEL_GHR, 32'h02);
    pushExp("ghr_idx3", SEL_IDX, 32'h07);
    checkOutput();

    applyStimulus(32'h14, 1'b0, 1'b1, 32'h14, 1'b1, 1'b0, 32'h0, 8'hFF, 8'h00, 1'b1);
    cyc();
    setFetch(32'h14, 1'b0);
    pushExp("ghr_zero", SEL_GHR, 32'h0);
    pushExp("btb_keep_taken", SEL_TAKEN, 32'd1);
    pushExp("btb_keep_pc", SEL_PC, 32'h200);
    checkOutput();

    // Tag alias on BTB index 5
    setFetch(32'h94, 1'b0);
    pushExp("alias_taken", SEL_TAKEN, 32'd0);
    pushExp("alias_pc", SEL_PC, 32'h98);
    checkOutput();

    // Mid-operation asynchronous reset
    setFetch(32'h100, 1'b0);
    pushExp("pre_rst_taken", SEL_TAKEN, 32'd1);
    pushExp("pre_rst_pc", SEL_PC, 32'h40);
    checkOutput();
    reset = 1'b0;
    #1;
    pushExp("async_ready", SEL_READY, 32'd0);
    pushExp("async_taken", SEL_TAKEN, 32'd0);
    pushExp("async_pc", SEL_PC, 32'h104);
    checkOutput();
    cyc();
    cyc();
    reset = 1'b1;
    waitReady(1'b0);
    setFetch(32'h100, 1'b0);
    pushExp("reinit_edges", SEL_EDGES, 32'd256);
    pushExp("reinit_ready", SEL_READY, 32'd1);
    pushExp("reinit_taken", SEL_TAKEN, 32'd0);
    pushExp("reinit_pc", SEL_PC, 32'h104);
    checkOutput();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
